// File: rtl/moto_cmd_ctrl.sv
// Motor command stage: key sync/debounce, soft-start/soft-stop duty ramp,
// and dead-time-protected direction reversal feeding the PWM generator.
module moto_cmd_ctrl #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_W      = 20,
  parameter int DUTY_W    = 8,
  parameter int SPEED_LO  = 128,
  parameter int SPEED_HI  = 255,
  parameter int RAMP_DIV  = 50_000,
  parameter int DEAD_CYC  = 500_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [3:0]        key,
  output logic [DUTY_W-1:0] duty,
  output logic              dir,
  output logic              pwm_en,
  output logic              busy
);

  localparam int PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);
  localparam logic [DUTY_W-1:0] DUTY_LO   = DUTY_W'(SPEED_LO);
  localparam logic [DUTY_W-1:0] DUTY_HI   = DUTY_W'(SPEED_HI);

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    HOLD,
    STOP,
    DEAD
  } state_t;

  logic [3:0]        sync1_q, sync2_q, keyDb_q;
  logic [DB_W-1:0]   dbCnt_q [4];

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dir_q, dir_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic              pwmEn_q, busy_q;

  logic [DUTY_W-1:0] target;
  logic              reqDir;
  logic              stepping;
  logic              tick;
  logic              deadDone;

  // Two-flop synchroniser, then a per-key counter that only accepts a level
  // after it has differed from the accepted value for DB_CYCLES straight cycles.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      keyDb_q <= '1;
      for (int i = 0; i < 4; i++) dbCnt_q[i] <= '0;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == keyDb_q[i]) begin
          dbCnt_q[i] <= '0;
        end else if (dbCnt_q[i] == DB_LAST) begin
          keyDb_q[i] <= sync2_q[i];
          dbCnt_q[i] <= '0;
        end else begin
          dbCnt_q[i] <= dbCnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Keys are active-low; enable gates everything, speed1 wins over speed0.
  always_comb begin
    target = '0;
    if (!keyDb_q[0]) begin
      if (!keyDb_q[3])      target = DUTY_HI;
      else if (!keyDb_q[2]) target = DUTY_LO;
    end
  end

  assign reqDir   = ~keyDb_q[1];
  assign stepping = (state_q == RAMP) || (state_q == STOP);
  assign tick     = stepping && (pre_q == PRE_LAST);
  assign deadDone = (state_q == DEAD) && (dead_q == DEAD_LAST);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        duty_d = '0;
        if (target != '0) begin
          dir_d   = reqDir;
          state_d = RAMP;
        end
      end
      RAMP: begin
        if ((reqDir != dir_q) && (duty_q != '0)) begin
          state_d = STOP;
        end else if (duty_q == target) begin
          state_d = (target == '0) ? IDLE : HOLD;
        end else if (tick) begin
          duty_d = (duty_q < target) ? duty_q + 1'b1 : duty_q - 1'b1;
        end
      end
      HOLD: begin
        if (reqDir != dir_q)       state_d = STOP;
        else if (target != duty_q) state_d = RAMP;
      end
      STOP: begin
        if (duty_q == '0) state_d = DEAD;
        else if (tick)    duty_d  = duty_q - 1'b1;
      end
      DEAD: begin
        duty_d = '0;
        if (deadDone) begin
          dir_d   = reqDir;
          state_d = (target != '0) ? RAMP : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        duty_d  = '0;
      end
    endcase
  end

  // Prescaler and dead timer restart on every state change so each phase
  // measures its own time from entry.
  always_comb begin
    pre_d = '0;
    if (stepping && (state_d == state_q) && !tick) pre_d = pre_q + 1'b1;
    dead_d = '0;
    if ((state_q == DEAD) && (state_d == DEAD)) dead_d = dead_q + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      pre_q   <= '0;
      dead_q  <= '0;
      pwmEn_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      pre_q   <= pre_d;
      dead_q  <= dead_d;
      pwmEn_q <= (duty_d != '0);
      busy_q  <= (state_d == RAMP) || (state_d == STOP) || (state_d == DEAD);
    end
  end

  assign duty   = duty_q;
  assign dir    = dir_q;
  assign pwm_en = pwmEn_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_moto_cmd_ctrl.sv
// Randomised and directed bench for moto_cmd_ctrl against a cycle-level
// behavioural model of debounce, ramping and reversal.
module tb_moto_cmd_ctrl;

  localparam int DB       = 4;
  localparam int RAMP_DIV = 2;
  localparam int DEAD     = 8;
  localparam int LO       = 4;
  localparam int HI       = 8;

  localparam int PH_IDLE = 0;
  localparam int PH_RAMP = 1;
  localparam int PH_HOLD = 2;
  localparam int PH_STOP = 3;
  localparam int PH_DEAD = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key = 4'hF;
  logic [3:0] duty;
  logic       dir, pwm_en, busy;

  int errors = 0;
  int checks = 0;

  int         mDuty, mPhase, mAge;
  bit         mDir;
  logic [3:0] mSync1, mSync2, mDb;
  int         mRun [4];
  int         prevDuty;
  bit         prevDir;

  moto_cmd_ctrl #(
    .DB_CYCLES(DB), .DB_W(3), .DUTY_W(4), .SPEED_LO(LO), .SPEED_HI(HI),
    .RAMP_DIV(RAMP_DIV), .DEAD_CYC(DEAD)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key),
    .duty(duty), .dir(dir), .pwm_en(pwm_en), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mDuty = 0; mDir = 0; mPhase = PH_IDLE; mAge = 0;
    mSync1 = 4'hF; mSync2 = 4'hF; mDb = 4'hF;
    for (int i = 0; i < 4; i++) mRun[i] = 0;
    prevDuty = 0; prevDir = 0;
  endtask

  // One clock edge of the reference: FSM sees the pre-edge debounced keys.
  task automatic modelStep(input logic [3:0] k);
    int  tgt, nPhase;
    bit  rd, tick;
    tgt = 0;
    if (!mDb[0]) tgt = !mDb[3] ? HI : (!mDb[2] ? LO : 0);
    rd   = !mDb[1];
    tick = (mPhase == PH_RAMP || mPhase == PH_STOP) && ((mAge + 1) % RAMP_DIV == 0);
    nPhase = mPhase;
    case (mPhase)
      PH_IDLE: if (tgt != 0) begin mDir = rd; nPhase = PH_RAMP; end
      PH_RAMP: begin
        if (rd != mDir && mDuty != 0) nPhase = PH_STOP;
        else if (mDuty == tgt) nPhase = (tgt == 0) ? PH_IDLE : PH_HOLD;
        else if (tick) mDuty += (mDuty < tgt) ? 1 : -1;
      end
      PH_HOLD: begin
        if (rd != mDir) nPhase = PH_STOP;
        else if (tgt != mDuty) nPhase = PH_RAMP;
      end
      PH_STOP: begin
        if (mDuty == 0) nPhase = PH_DEAD;
        else if (tick) mDuty -= 1;
      end
      default: if (mAge == DEAD - 1) begin
        mDir = rd;
        nPhase = (tgt != 0) ? PH_RAMP : PH_IDLE;
      end
    endcase
    mAge = (nPhase != mPhase) ? 0 : mAge + 1;
    mPhase = nPhase;
    for (int i = 0; i < 4; i++) begin
      if (mSync2[i] == mDb[i]) mRun[i] = 0;
      else begin
        mRun[i]++;
        if (mRun[i] == DB) begin mDb[i] = mSync2[i]; mRun[i] = 0; end
      end
    end
    mSync2 = mSync1;
    mSync1 = k;
  endtask

  task automatic compareAll();
    checkOutput("duty", int'(duty), mDuty);
    checkOutput("dir", int'(dir), int'(mDir));
    checkOutput("pwmEn", int'(pwm_en), int'(mDuty != 0));
    checkOutput("busy", int'(busy),
                int'(mPhase == PH_RAMP || mPhase == PH_STOP || mPhase == PH_DEAD));
    if (dir != prevDir) checkOutput("dirFlipDuty", prevDuty, 0);
    prevDir  = dir;
    prevDuty = int'(duty);
  endtask

  // Caller is at a negedge; returns at the next negedge.
  task automatic applyStimulus(input logic [3:0] k, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      key = k;
      modelStep(k);
      @(posedge sys_clk);
      #1;
      compareAll();
      @(negedge sys_clk);
    end
  endtask

  task automatic midReset();
    #2 sys_rst_n = 1'b0;
    #1 modelReset();
    compareAll();
    @(negedge sys_clk);
    compareAll();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [3:0] k;
    modelReset();
    #1 compareAll();
    repeat (2) begin @(posedge sys_clk); #1 compareAll(); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    applyStimulus(4'hF, 5);

    // Short enable glitch with speed0 held must not start a ramp.
    applyStimulus(4'b1011, 10);
    applyStimulus(4'b1010, 3);
    applyStimulus(4'b1011, 10);
    checkOutput("glitchBusy", int'(busy), 0);

    // Sync (2) + debounce (DB) + one FSM edge before busy rises.
    cnt = 0;
    while (cnt < 20 && !busy) begin applyStimulus(4'b1010, 1); cnt++; end
    checkOutput("enLatency", cnt, DB + 3);

    applyStimulus(4'b1010, 20);
    checkOutput("hold4", int'(duty), LO);
    applyStimulus(4'b0010, 30);
    checkOutput("hold8", int'(duty), HI);
    applyStimulus(4'b0011, 40);
    checkOutput("rampDown", int'(duty), 0);

    applyStimulus(4'b0110, 40);
    applyStimulus(4'b0100, 60);
    checkOutput("revDir", int'(dir), 1);
    checkOutput("revDuty", int'(duty), HI);
    applyStimulus(4'hF, 40);

    cnt = 0;
    while (cnt < 60 && !(mPhase == PH_RAMP && mDuty == 3)) begin
      applyStimulus(4'b1010, 1); cnt++;
    end
    checkOutput("reachDuty3", mDuty, 3);
    midReset();
    checkOutput("rstDuty", int'(duty), 0);
    applyStimulus(4'b1010, 30);

    for (int s = 0; s < 300; s++) begin
      k = 4'($urandom);
      k[0] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) applyStimulus(k, $urandom_range(1, 4));
      else applyStimulus(k, $urandom_range(5, 40));
      if ($urandom_range(0, 39) == 0) midReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
